hex_display_streamer: RTL and testbench

- Multi-channel hex-to-ASCII character streamer feeding the character display buffer.
- Each channel owns one display row. A channel latches a binary value, converts it nibble by nibble into ASCII hex digits, and writes one character per cycle into a contiguous column range.
- Successor to the single fixed-width cycle-count display path: parametrised in value width, channel count and start column.
- Adds round-robin arbitration between channels and optional leading-zero blanking.

---
 rtl/hex_display_streamer.sv | 177 +++++++++++++++++
 tb/tb_hex_display_streamer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_streamer.sv
// Multi-channel hex-to-ASCII streamer: each channel latches a value and writes it
// as upper-case hex characters into its own display row, round-robin arbitrated.
module hex_display_streamer #(
   parameter int NUM_CH    = 4,
   parameter int VAL_WIDTH = 32,
   parameter int DIGITS    = (VAL_WIDTH + 3) / 4,
   parameter int COL_BASE  = 8,
   parameter int COL_NUM   = 16,
   parameter int ROW_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int COL_WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           in_valid,
   input  logic [NUM_CH*VAL_WIDTH-1:0] in_value,
   output logic [NUM_CH-1:0]           in_ready,
   input  logic                        blank_lz,
   output logic                        wr_en,
   output logic [ROW_WIDTH-1:0]        wr_row,
   output logic [COL_WIDTH-1:0]        wr_col,
   output logic [7:0]                  wr_char,
   output logic                        busy,
   output logic                        done,
   output logic [ROW_WIDTH-1:0]        done_ch
);

   localparam int SW = DIGITS * 4;
   localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   generate
      if (COL_BASE + DIGITS > COL_NUM) begin : g_col_check
         $error("hex_display_streamer: COL_BASE + DIGITS exceeds COL_NUM");
      end
   endgenerate

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t                 state, state_next;
   logic [NUM_CH-1:0]      pending;
   logic [VAL_WIDTH-1:0]   hold [NUM_CH];
   logic [SW-1:0]          shift;
   logic [KW-1:0]          k;
   logic                   blz;
   logic                   lz_active;
   logic [ROW_WIDTH-1:0]   rr;
   logic [ROW_WIDTH-1:0]   cur_ch;

   logic                   any_pend;
   logic                   gnt_found;
   logic [ROW_WIDTH-1:0]   gnt_idx;
   logic [ROW_WIDTH-1:0]   rr_next;
   logic [NUM_CH-1:0]      gnt_mask;
   logic                   grant;
   logic                   last;
   logic [3:0]             nib;
   logic [7:0]             char_c;

   assign in_ready = ~pending;
   assign busy     = (state == EMIT);
   assign any_pend = |pending;
   assign nib      = shift[SW-1 -: 4];
   assign last     = (k == KW'(DIGITS - 1));
   assign rr_next  = (gnt_idx == ROW_WIDTH'(NUM_CH - 1)) ? '0 : gnt_idx + ROW_WIDTH'(1);

   // First pending channel at or after the round-robin pointer, wrapping around.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!gnt_found && pending[(int'(rr) + i) % NUM_CH]) begin
            gnt_found = 1'b1;
            gnt_idx   = ROW_WIDTH'((int'(rr) + i) % NUM_CH);
         end
      end
   end

   // The final digit always prints, so an all-zero value still shows one "0".
   always_comb begin
      char_c = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
      if (blz && lz_active && (nib == 4'h0) && !last) begin
         char_c = 8'h20;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A grant at the last digit chains straight into the next value with no gap cycle.
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      gnt_mask   = '0;
      case (state)
         IDLE: begin
            if (any_pend) begin
               grant      = 1'b1;
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (last) begin
               if (any_pend) begin
                  grant = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (grant) begin
         gnt_mask[gnt_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            hold[i] <= '0;
         end
         shift     <= '0;
         k         <= '0;
         blz       <= 1'b0;
         lz_active <= 1'b0;
         rr        <= '0;
         cur_ch    <= '0;
         wr_en     <= 1'b0;
         wr_row    <= '0;
         wr_col    <= '0;
         wr_char   <= '0;
         done      <= 1'b0;
         done_ch   <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (in_valid[i] && !pending[i]) begin
               hold[i] <= in_value[i*VAL_WIDTH +: VAL_WIDTH];
            end
         end
         pending <= (pending | (in_valid & ~pending)) & ~gnt_mask;

         if (state == EMIT) begin
            wr_en   <= 1'b1;
            wr_row  <= cur_ch;
            wr_col  <= COL_WIDTH'(COL_BASE) + COL_WIDTH'(k);
            wr_char <= char_c;
            done    <= last;
            if (last) begin
               done_ch <= cur_ch;
            end
            shift <= shift << 4;
            k     <= k + KW'(1);
            if (nib != 4'h0) begin
               lz_active <= 1'b0;
            end
         end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
         end

         if (grant) begin
            shift     <= SW'(hold[gnt_idx]);
            cur_ch    <= gnt_idx;
            blz       <= blank_lz;
            k         <= '0;
            lz_active <= 1'b1;
            rr        <= rr_next;
         end
      end
   end

endmodule

// File: tb/tb_hex_display_streamer.sv
// Bench for hex_display_streamer: directed and randomized captures compared against
// a transaction-level model of the character stream each batch of values produces.
module tb_hex_display_streamer;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   in_valid;
   logic [127:0] in_value;
   logic [3:0]   in_ready;
   logic         blank_lz;
   logic         wr_en;
   logic [1:0]   wr_row;
   logic [3:0]   wr_col;
   logic [7:0]   wr_char;
   logic         busy;
   logic         done;
   logic [1:0]   done_ch;

   logic [1:0]   n_valid;
   logic [19:0]  n_value;
   logic [1:0]   n_ready;
   logic         n_wr_en;
   logic [0:0]   n_wr_row;
   logic [3:0]   n_wr_col;
   logic [7:0]   n_wr_char;
   logic         n_busy;
   logic         n_done;
   logic [0:0]   n_done_ch;

   typedef struct packed {
      logic [1:0] row;
      logic [3:0] col;
      logic [7:0] ch;
      logic       done;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] vals[4];
   int          rr_m = 0;
   int          checks = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   hex_display_streamer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value), .in_ready(in_ready),
      .blank_lz(blank_lz), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
      .busy(busy), .done(done), .done_ch(done_ch)
   );

   hex_display_streamer #(.NUM_CH(2), .VAL_WIDTH(10), .COL_BASE(13)) dut_narrow (
      .clk(clk), .rst(rst), .in_valid(n_valid), .in_value(n_value), .in_ready(n_ready),
      .blank_lz(blank_lz), .wr_en(n_wr_en), .wr_row(n_wr_row), .wr_col(n_wr_col), .wr_char(n_wr_char),
      .busy(n_busy), .done(n_done), .done_ch(n_done_ch)
   );

   function automatic logic [7:0] hex_char(input int n);
      return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
   endfunction

   // One value as the display should show it, most significant digit first.
   task automatic model_emit(input int ch, input logic [31:0] v, input bit b, input int digits, input int base);
      bit  seen = 1'b0;
      wr_t e;
      for (int kk = 0; kk < digits; kk++) begin
         int nb;
         nb = int'((v >> ((digits - 1 - kk) * 4)) & 32'hF);
         if (nb != 0) seen = 1'b1;
         e.row  = 2'(ch);
         e.col  = 4'(base + kk);
         e.ch   = (b && !seen && kk < digits - 1) ? 8'h20 : hex_char(nb);
         e.done = (kk == digits - 1);
         exp_q.push_back(e);
      end
   endtask

   // Channels captured together are served in rotating order from the pointer.
   task automatic model_batch(input logic [3:0] mask, input bit b);
      int lastc = 0;
      for (int i = 0; i < 4; i++) begin
         int c;
         c = (rr_m + i) % 4;
         if (mask[c]) begin
            model_emit(c, vals[c], b, 8, 8);
            lastc = c;
         end
      end
      rr_m = (lastc + 1) % 4;
   endtask

   task automatic apply_capture(input logic [3:0] mask, input bit b);
      in_valid = mask;
      blank_lz = b;
      for (int i = 0; i < 4; i++) in_value[i*32 +: 32] = vals[i];
      @(negedge clk);
      in_valid = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({wr_en, wr_row, wr_col, wr_char, busy, done, done_ch} !== 18'h0 || in_ready !== 4'hF || n_ready !== 2'b11)
         $display("[TB] FAIL reset_state: got en=%b row=%0d col=%0d char=%h busy=%b done=%b dch=%0d rdy=%b nrdy=%b, want all 0 rdy=1111 nrdy=11",
                  wr_en, wr_row, wr_col, wr_char, busy, done, done_ch, in_ready, n_ready);
      else passed++;
      rst = 1'b0;
      rr_m = 0;
      @(negedge clk);
   endtask

   task automatic test_single();
      int L;
      vals[0] = 32'h0000_1A2F;
      model_batch(4'b0001, 1'b0);
      L = exp_q.size();
      apply_capture(4'b0001, 1'b0);
      for (int n = 0; n < L + 4; n++) begin
         if (n > 0) @(negedge clk);
         checks++;
         if (n >= 2 && n < L + 2) begin
            wr_t e = exp_q[n-2];
            if ({wr_en, wr_row, wr_col, wr_char, done} !== {1'b1, e.row, e.col, e.ch, e.done} || (e.done && done_ch !== e.row))
               $display("[TB] FAIL single n=%0d: got en=%b row=%0d col=%0d char=%h done=%b dch=%0d, want row=%0d col=%0d char=%h done=%b",
                        n, wr_en, wr_row, wr_col, wr_char, done, done_ch, e.row, e.col, e.ch, e.done);
            else passed++;
         end else if (wr_en !== 1'b0) $display("[TB] FAIL single_idle n=%0d: got wr_en=%b want 0", n, wr_en);
         else passed++;
      end
      exp_q.delete();
   endtask

   task automatic test_blank();
      logic [31:0] cases[2] = '{32'h0000_1A2F, 32'h0};
      for (int c = 0; c < 2; c++) begin
         int L;
         vals[0] = cases[c];
         model_batch(4'b0001, 1'b1);
         L = exp_q.size();
         apply_capture(4'b0001, 1'b1);
         for (int n = 0; n < L + 4; n++) begin
            if (n > 0) @(negedge clk);
            checks++;
            if (n >= 2 && n < L + 2) begin
               wr_t e = exp_q[n-2];
               if ({wr_en, wr_row, wr_col, wr_char, done} !== {1'b1, e.row, e.col, e.ch, e.done})
                  $display("[TB] FAIL blank v=%h n=%0d: got en=%b row=%0d col=%0d char=%h done=%b, want row=%0d col=%0d char=%h done=%b",
                           cases[c], n, wr_en, wr_row, wr_col, wr_char, done, e.row, e.col, e.ch, e.done);
               else passed++;
            end else if (wr_en !== 1'b0) $display("[TB] FAIL blank_idle n=%0d: got wr_en=%b want 0", n, wr_en);
            else passed++;
         end
         exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      int L;
      int busy_cnt = 0;
      vals[1] = $urandom;
      vals[3] = $urandom;
      model_batch(4'b1010, 1'b0);
      L = exp_q.size();
      apply_capture(4'b1010, 1'b0);
      for (int n = 0; n < L + 4; n++) begin
         if (n > 0) @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         checks++;
         if (n >= 2 && n < L + 2) begin
            wr_t e = exp_q[n-2];
            if ({wr_en, wr_row, wr_col, wr_char, done} !== {1'b1, e.row, e.col, e.ch, e.done} || (e.done && done_ch !== e.row))
               $display("[TB] FAIL b2b n=%0d: got en=%b row=%0d col=%0d char=%h done=%b dch=%0d, want row=%0d col=%0d char=%h done=%b",
                        n, wr_en, wr_row, wr_col, wr_char, done, done_ch, e.row, e.col, e.ch, e.done);
            else passed++;
         end else if (wr_en !== 1'b0) $display("[TB] FAIL b2b_idle n=%0d: got wr_en=%b want 0", n, wr_en);
         else passed++;
      end
      checks++;
      if (busy_cnt !== 16) $display("[TB] FAIL b2b_busy: got %0d busy cycles want 16", busy_cnt);
      else passed++;
      exp_q.delete();
   endtask

   // ch1 is recaptured during its own emission alongside ch2; the pointer favours ch2.
   task automatic test_rr();
      int          L;
      logic [31:0] v2, v3;
      vals[1] = $urandom;
      v2 = $urandom;
      v3 = $urandom;
      model_emit(1, vals[1], 1'b0, 8, 8);
      model_emit(2, v2, 1'b0, 8, 8);
      model_emit(1, v3, 1'b0, 8, 8);
      rr_m = 2;
      L = exp_q.size();
      apply_capture(4'b0010, 1'b0);
      for (int n = 0; n < L + 4; n++) begin
         logic exp_rdy;
         if (n > 0) @(negedge clk);
         exp_rdy = !(n == 0 || (n >= 4 && n < 17));
         checks++;
         if (n >= 2 && n < L + 2) begin
            wr_t e = exp_q[n-2];
            if ({wr_en, wr_row, wr_col, wr_char, done} !== {1'b1, e.row, e.col, e.ch, e.done} || (e.done && done_ch !== e.row))
               $display("[TB] FAIL rr n=%0d: got en=%b row=%0d col=%0d char=%h done=%b dch=%0d, want row=%0d col=%0d char=%h done=%b",
                        n, wr_en, wr_row, wr_col, wr_char, done, done_ch, e.row, e.col, e.ch, e.done);
            else passed++;
         end else if (wr_en !== 1'b0) $display("[TB] FAIL rr_idle n=%0d: got wr_en=%b want 0", n, wr_en);
         else passed++;
         checks++;
         if (in_ready[1] !== exp_rdy) $display("[TB] FAIL rr_ready1 n=%0d: got %b want %b", n, in_ready[1], exp_rdy);
         else passed++;
         if (n == 3) begin
            in_value[32 +: 32] = v3;
            in_value[64 +: 32] = v2;
            in_valid = 4'b0110;
         end else if (n == 4) begin
            in_valid = '0;
         end
      end
      exp_q.delete();
   endtask

   task automatic test_random();
      for (int r = 0; r < 12; r++) begin
         int         L;
         logic [3:0] mask;
         bit         b;
         mask = 4'($urandom_range(1, 15));
         b    = 1'($urandom_range(0, 1));
         for (int i = 0; i < 4; i++) vals[i] = $urandom >> $urandom_range(0, 32);
         model_batch(mask, b);
         L = exp_q.size();
         apply_capture(mask, b);
         for (int n = 0; n < L + 4; n++) begin
            if (n > 0) @(negedge clk);
            checks++;
            if (n >= 2 && n < L + 2) begin
               wr_t e = exp_q[n-2];
               if ({wr_en, wr_row, wr_col, wr_char, done} !== {1'b1, e.row, e.col, e.ch, e.done} || (e.done && done_ch !== e.row))
                  $display("[TB] FAIL random r=%0d n=%0d: got en=%b row=%0d col=%0d char=%h done=%b dch=%0d, want row=%0d col=%0d char=%h done=%b",
                           r, n, wr_en, wr_row, wr_col, wr_char, done, done_ch, e.row, e.col, e.ch, e.done);
               else passed++;
            end else if (wr_en !== 1'b0) $display("[TB] FAIL random_idle r=%0d n=%0d: got wr_en=%b want 0", r, n, wr_en);
            else passed++;
         end
         exp_q.delete();
      end
   endtask

   task automatic test_narrow();
      int L;
      model_emit(0, 32'h3FF, 1'b0, 3, 13);
      L = exp_q.size();
      blank_lz = 1'b0;
      n_value  = 20'h003FF;
      n_valid  = 2'b01;
      @(negedge clk);
      n_valid = '0;
      for (int n = 0; n < L + 4; n++) begin
         if (n > 0) @(negedge clk);
         checks++;
         if (n >= 2 && n < L + 2) begin
            wr_t e = exp_q[n-2];
            if ({n_wr_en, 1'b0, n_wr_row, n_wr_col, n_wr_char, n_done} !== {1'b1, e.row, e.col, e.ch, e.done} || (e.done && n_done_ch !== 1'b0))
               $display("[TB] FAIL narrow n=%0d: got en=%b row=%0d col=%0d char=%h done=%b, want row=%0d col=%0d char=%h done=%b",
                        n, n_wr_en, n_wr_row, n_wr_col, n_wr_char, n_done, e.row, e.col, e.ch, e.done);
            else passed++;
         end else if (n_wr_en !== 1'b0) $display("[TB] FAIL narrow_idle n=%0d: got wr_en=%b want 0", n, n_wr_en);
         else passed++;
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int  stray = 0;
      wr_t e;
      vals[0] = $urandom | 32'h1000_0000;
      vals[2] = $urandom;
      model_batch(4'b0101, 1'b0);
      e = exp_q[3];
      apply_capture(4'b0101, 1'b0);
      repeat (5) @(negedge clk);
      checks++;
      if ({wr_en, wr_row, wr_col, wr_char} !== {1'b1, e.row, e.col, e.ch})
         $display("[TB] FAIL mid_fourth: got en=%b row=%0d col=%0d char=%h, want row=%0d col=%0d char=%h",
                  wr_en, wr_row, wr_col, wr_char, e.row, e.col, e.ch);
      else passed++;
      rst = 1'b1;
      #1;
      checks++;
      if ({wr_en, wr_row, wr_col, wr_char, busy, done, done_ch} !== 18'h0 || in_ready !== 4'hF)
         $display("[TB] FAIL mid_reset: got en=%b row=%0d col=%0d char=%h busy=%b done=%b rdy=%b, want all 0 rdy=1111",
                  wr_en, wr_row, wr_col, wr_char, busy, done, in_ready);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      rr_m = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (wr_en !== 1'b0 || busy !== 1'b0) stray++;
      end
      checks++;
      if (stray !== 0 || in_ready !== 4'hF)
         $display("[TB] FAIL mid_after: got %0d active cycles rdy=%b, want 0 active rdy=1111", stray, in_ready);
      else passed++;
      exp_q.delete();
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = '0;
      in_value = '0;
      blank_lz = 1'b0;
      n_valid  = '0;
      n_value  = '0;
      test_reset();
      test_single();
      test_blank();
      test_back_to_back();
      test_rr();
      test_random();
      test_narrow();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
